// File: rtl/ccip_rd_tracker.sv
// Read-request tag tracker: allocates tags from a free FIFO, restores port/mdata
// on responses, and releases a tag once every line of its block has returned.
module ccip_rd_tracker #(
   parameter int NUM_PORTS  = 2,
   parameter int L_MAX_RDS  = 7,
   parameter int BLK_SIZE   = 4,
   parameter int MDATA_W    = 16,
   parameter int ALMFULL_TH = 8,
   localparam int LP = (NUM_PORTS == 1) ? 1 : $clog2(NUM_PORTS),
   localparam int LB = $clog2(BLK_SIZE)
) (
   input  logic                 clk,
   input  logic                 SoftReset,
   output logic                 InitDn,
   output logic                 TxAlmFull,
   input  logic                 req_valid,
   input  logic [LP-1:0]        req_port,
   input  logic [MDATA_W-1:0]   req_mdata,
   input  logic [41:0]          req_addr,
   input  logic [LB-1:0]        req_len,
   output logic                 dn_valid,
   output logic [L_MAX_RDS-1:0] dn_tag,
   output logic [41:0]          dn_addr,
   output logic [LB-1:0]        dn_len,
   input  logic                 rsp_valid,
   input  logic [L_MAX_RDS-1:0] rsp_tag,
   input  logic [LB-1:0]        rsp_clnum,
   input  logic [511:0]         rsp_data,
   output logic                 up_valid,
   output logic [LP-1:0]        up_port,
   output logic [MDATA_W-1:0]   up_mdata,
   output logic [LB-1:0]        up_clnum,
   output logic [511:0]         up_data,
   output logic                 up_last,
   output logic [L_MAX_RDS:0]   outstanding,
   output logic                 err_ovf,
   output logic                 err_unalloc,
   output logic                 err_dup
);

   localparam int N  = 1 << L_MAX_RDS;
   localparam int MW = 1 << LB;

   typedef enum logic {INIT, RUN} state_t;
   state_t state;

   logic [L_MAX_RDS-1:0] fifo_mem [N];
   logic [L_MAX_RDS-1:0] rd_ptr, wr_ptr, init_cnt;
   logic [L_MAX_RDS:0]   free_cnt;
   logic [N-1:0]         live;

   logic [LP-1:0]      port_mem  [N];
   logic [MDATA_W-1:0] mdata_mem [N];
   logic [LB-1:0]      len_mem   [N];
   logic [MW-1:0]      mask_mem  [N];

   logic [L_MAX_RDS-1:0] head;
   logic                 alloc, drop, rsp_live, rsp_fresh, accept, release_tag;
   logic [MW-1:0]        cur_mask, line_bit, need, next_mask;

   always_comb begin
      head     = fifo_mem[rd_ptr];
      alloc    = (state == RUN) && req_valid && (free_cnt != '0);
      drop     = (state == RUN) && req_valid && (free_cnt == '0);
      rsp_live = live[rsp_tag];
      cur_mask = mask_mem[rsp_tag];
      line_bit = '0;
      line_bit[rsp_clnum] = 1'b1;
      need = '0;
      for (int unsigned i = 0; i < MW; i++) begin
         need[i] = (LB'(i) <= len_mem[rsp_tag]);
      end
      // a line is fresh only if it lies within the block and has not been seen yet
      rsp_fresh   = (rsp_clnum <= len_mem[rsp_tag]) && ((cur_mask & line_bit) == '0);
      accept      = (state == RUN) && rsp_valid && rsp_live && rsp_fresh;
      next_mask   = cur_mask | line_bit;
      release_tag = accept && ((next_mask & need) == need);
   end

   always_ff @(posedge clk) begin
      if (SoftReset) begin
         state       <= INIT;
         init_cnt    <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         free_cnt    <= '0;
         live        <= '0;
         InitDn      <= 1'b0;
         TxAlmFull   <= 1'b1;
         dn_valid    <= 1'b0;
         up_valid    <= 1'b0;
         up_last     <= 1'b0;
         outstanding <= '0;
         err_ovf     <= 1'b0;
         err_unalloc <= 1'b0;
         err_dup     <= 1'b0;
      end else begin
         dn_valid <= alloc;
         up_valid <= accept;
         up_last  <= release_tag;
         if (state == INIT) begin
            wr_ptr    <= wr_ptr + L_MAX_RDS'(1);
            free_cnt  <= free_cnt + (L_MAX_RDS+1)'(1);
            init_cnt  <= init_cnt + L_MAX_RDS'(1);
            TxAlmFull <= 1'b1;
            if (init_cnt == L_MAX_RDS'(N - 1)) begin
               state  <= RUN;
               InitDn <= 1'b1;
            end
         end else begin
            TxAlmFull <= ((N - int'(outstanding)) <= ALMFULL_TH);
            if (alloc) begin
               rd_ptr     <= rd_ptr + L_MAX_RDS'(1);
               live[head] <= 1'b1;
            end
            if (release_tag) begin
               wr_ptr        <= wr_ptr + L_MAX_RDS'(1);
               live[rsp_tag] <= 1'b0;
            end
            // free list sees the release only after this edge, so a same-cycle
            // request against an empty list is still dropped
            case ({alloc, release_tag})
               2'b10: begin
                  free_cnt    <= free_cnt - (L_MAX_RDS+1)'(1);
                  outstanding <= outstanding + (L_MAX_RDS+1)'(1);
               end
               2'b01: begin
                  free_cnt    <= free_cnt + (L_MAX_RDS+1)'(1);
                  outstanding <= outstanding - (L_MAX_RDS+1)'(1);
               end
               default: ;
            endcase
            if (drop)                                err_ovf     <= 1'b1;
            if (rsp_valid && !rsp_live)              err_unalloc <= 1'b1;
            if (rsp_valid && rsp_live && !rsp_fresh) err_dup     <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!SoftReset) begin
         if (state == INIT) begin
            fifo_mem[wr_ptr] <= init_cnt;
         end else if (release_tag) begin
            fifo_mem[wr_ptr] <= rsp_tag;
         end
         if (accept) mask_mem[rsp_tag] <= next_mask;
         if (alloc) begin
            port_mem[head]  <= req_port;
            mdata_mem[head] <= req_mdata;
            len_mem[head]   <= req_len;
            mask_mem[head]  <= '0;
         end
      end
      dn_tag   <= head;
      dn_addr  <= req_addr;
      dn_len   <= req_len;
      up_port  <= port_mem[rsp_tag];
      up_mdata <= mdata_mem[rsp_tag];
      up_clnum <= rsp_clnum;
      up_data  <= rsp_data;
   end

endmodule

// File: tb/tb_ccip_rd_tracker.sv
// Directed bench for ccip_rd_tracker with an 8-tag table and 4-line blocks.
module tb_ccip_rd_tracker;

   localparam int LP = 1;
   localparam int LB = 2;
   localparam int LM = 3;

   logic               clk = 1'b0;
   logic               SoftReset;
   logic               InitDn, TxAlmFull;
   logic               req_valid;
   logic [LP-1:0]      req_port;
   logic [15:0]        req_mdata;
   logic [41:0]        req_addr;
   logic [LB-1:0]      req_len;
   logic               dn_valid;
   logic [LM-1:0]      dn_tag;
   logic [41:0]        dn_addr;
   logic [LB-1:0]      dn_len;
   logic               rsp_valid;
   logic [LM-1:0]      rsp_tag;
   logic [LB-1:0]      rsp_clnum;
   logic [511:0]       rsp_data;
   logic               up_valid;
   logic [LP-1:0]      up_port;
   logic [15:0]        up_mdata;
   logic [LB-1:0]      up_clnum;
   logic [511:0]       up_data;
   logic               up_last;
   logic [LM:0]        outstanding;
   logic               err_ovf, err_unalloc, err_dup;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;
   logic [1:0]   ord [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
   logic [511:0] d;

   ccip_rd_tracker #(
      .NUM_PORTS(2), .L_MAX_RDS(3), .BLK_SIZE(4), .MDATA_W(16), .ALMFULL_TH(2)
   ) dut (
      .clk(clk), .SoftReset(SoftReset), .InitDn(InitDn), .TxAlmFull(TxAlmFull),
      .req_valid(req_valid), .req_port(req_port), .req_mdata(req_mdata),
      .req_addr(req_addr), .req_len(req_len),
      .dn_valid(dn_valid), .dn_tag(dn_tag), .dn_addr(dn_addr), .dn_len(dn_len),
      .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .rsp_clnum(rsp_clnum), .rsp_data(rsp_data),
      .up_valid(up_valid), .up_port(up_port), .up_mdata(up_mdata), .up_clnum(up_clnum),
      .up_data(up_data), .up_last(up_last), .outstanding(outstanding),
      .err_ovf(err_ovf), .err_unalloc(err_unalloc), .err_dup(err_dup)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic reset_pulse();
      SoftReset = 1'b1;
      step();
      step();
   endtask

   task automatic wait_init(output int cycles);
      SoftReset = 1'b0;
      cycles = 0;
      while (!InitDn && cycles < 20) begin
         step();
         cycles++;
      end
   endtask

   initial begin
      SoftReset = 1'b1; req_valid = 1'b0; req_port = '0; req_mdata = '0;
      req_addr = '0; req_len = '0; rsp_valid = 1'b0; rsp_tag = '0;
      rsp_clnum = '0; rsp_data = '0;

      // reset state, with traffic present that INIT must ignore
      req_valid = 1'b1; rsp_valid = 1'b1; rsp_tag = 3'd3;
      reset_pulse();
      chk("rst_initdn", InitDn, 0);
      chk("rst_almfull", TxAlmFull, 1);
      chk("rst_dn_valid", dn_valid, 0);
      chk("rst_up_valid", up_valid, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_errs", {err_ovf, err_unalloc, err_dup}, 0);
      wait_init(cyc);
      chk("init_cycles", cyc, 8);
      req_valid = 1'b0; rsp_valid = 1'b0;
      chk("init_no_err", {err_ovf, err_unalloc, err_dup}, 0);
      chk("init_no_alloc", outstanding, 0);
      step();
      chk("run_almfull", TxAlmFull, 0);

      // 4-line request, lines returned out of order
      req_valid = 1'b1; req_port = 1'b1; req_mdata = 16'hBEEF;
      req_addr = 42'h123_4567_89A; req_len = 2'd3;
      step();
      req_valid = 1'b0;
      chk("b_dn_valid", dn_valid, 1);
      chk("b_dn_tag", dn_tag, 0);
      chk("b_dn_addr", dn_addr, 42'h123_4567_89A);
      chk("b_dn_len", dn_len, 3);
      chk("b_outstanding", outstanding, 1);
      for (int i = 0; i < 4; i++) begin
         d = {16{32'hC0DE_0000 + 32'(ord[i])}};
         rsp_valid = 1'b1; rsp_tag = 3'd0; rsp_clnum = ord[i]; rsp_data = d;
         step();
         chk("b_up_valid", up_valid, 1);
         chk("b_up_port", up_port, 1);
         chk("b_up_mdata", up_mdata, 16'hBEEF);
         chk("b_up_clnum", up_clnum, ord[i]);
         chk("b_up_data", up_data, d);
         chk("b_up_last", up_last, (i == 3));
      end
      rsp_valid = 1'b0;
      chk("b_outstanding_end", outstanding, 0);
      chk("b_no_err", {err_ovf, err_unalloc, err_dup}, 0);
      req_valid = 1'b1; req_port = 1'b0; req_mdata = 16'h1111; req_len = 2'd1;
      step();
      req_valid = 1'b0;
      chk("b2_dn_tag", dn_tag, 1);

      // reset with tag 1 live; its late response only errors once back in RUN
      rsp_valid = 1'b1; rsp_tag = 3'd1; rsp_clnum = 2'd0;
      reset_pulse();
      chk("c_outstanding", outstanding, 0);
      chk("c_up_valid", up_valid, 0);
      wait_init(cyc);
      chk("c_init_cycles", cyc, 8);
      chk("c_init_no_unalloc", err_unalloc, 0);
      step();
      rsp_valid = 1'b0;
      chk("c_up_valid_run", up_valid, 0);
      chk("c_unalloc", err_unalloc, 1);

      // nine back-to-back single-line requests into 8 tags
      reset_pulse();
      wait_init(cyc);
      req_valid = 1'b1; req_len = 2'd0;
      for (int k = 0; k < 9; k++) begin
         req_mdata = 16'(k);
         step();
         chk("d_dn_valid", dn_valid, (k < 8));
         if (k < 8) chk("d_dn_tag", dn_tag, k);
         chk("d_ovf", err_ovf, (k == 8));
      end
      req_valid = 1'b0;
      chk("d_outstanding", outstanding, 8);
      chk("d_almfull", TxAlmFull, 1);

      // full table: release of tag 5 and a request in the same cycle
      reset_pulse();
      wait_init(cyc);
      req_valid = 1'b1; req_len = 2'd0;
      for (int k = 0; k < 8; k++) begin
         req_mdata = 16'h5000 + 16'(k);
         step();
      end
      chk("e_outstanding_full", outstanding, 8);
      chk("e_no_ovf", err_ovf, 0);
      req_mdata = 16'hAAAA;
      rsp_valid = 1'b1; rsp_tag = 3'd5; rsp_clnum = 2'd0;
      step();
      rsp_valid = 1'b0;
      chk("e_dn_dropped", dn_valid, 0);
      chk("e_ovf", err_ovf, 1);
      chk("e_up_valid", up_valid, 1);
      chk("e_up_last", up_last, 1);
      chk("e_up_mdata", up_mdata, 16'h5005);
      chk("e_outstanding_rel", outstanding, 7);
      step();
      req_valid = 1'b0;
      chk("e_dn_valid", dn_valid, 1);
      chk("e_dn_tag_reuse", dn_tag, 5);
      chk("e_outstanding_refill", outstanding, 8);

      // unallocated tag, duplicate and out-of-range lines, alloc+release together
      reset_pulse();
      wait_init(cyc);
      rsp_valid = 1'b1; rsp_tag = 3'd2; rsp_clnum = 2'd0;
      step();
      rsp_valid = 1'b0;
      chk("f_unalloc_up", up_valid, 0);
      chk("f_unalloc", err_unalloc, 1);
      chk("f_no_dup", err_dup, 0);
      req_valid = 1'b1; req_mdata = 16'h000A; req_len = 2'd1;
      step();
      chk("f_tag0", dn_tag, 0);
      req_mdata = 16'h000B; req_len = 2'd0;
      step();
      req_valid = 1'b0;
      chk("f_tag1", dn_tag, 1);
      chk("f_outstanding2", outstanding, 2);
      rsp_valid = 1'b1; rsp_tag = 3'd0; rsp_clnum = 2'd0;
      step();
      chk("f_line0_up", up_valid, 1);
      chk("f_line0_last", up_last, 0);
      chk("f_line0_mdata", up_mdata, 16'h000A);
      step();
      chk("f_dup_up", up_valid, 0);
      chk("f_dup", err_dup, 1);
      rsp_tag = 3'd1; rsp_clnum = 2'd2;
      step();
      chk("f_range_up", up_valid, 0);
      chk("f_range_keeps_tag", outstanding, 2);
      rsp_tag = 3'd0; rsp_clnum = 2'd1;
      req_valid = 1'b1; req_mdata = 16'h000C; req_len = 2'd0;
      step();
      rsp_valid = 1'b0; req_valid = 1'b0;
      chk("f_line1_last", up_last, 1);
      chk("f_line1_up", up_valid, 1);
      chk("f_tag2", dn_tag, 2);
      chk("f_outstanding_same", outstanding, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
